pmon_i2c_arbiter: RTL and testbench
===================================

# pmon_i2c_arbiter

Shares the single power-monitor I2C bus and its three transaction engines (write-pointer, read-word, write-word) between up to NREQ independent requesters, e.g. the register poller, the configuration writer and the alert service. It runs in the CLK_24 domain:
- grants the bus round-robin;
- sequences each engine's level GO / END handshake across the 400 kHz engine clock boundary;
- returns read data and a completion or error pulse to the winning requester.

## Interface
Parameters:
- NREQ, 3: number of requesters (2..8).
- GAP_CYCLES, 128: minimum CLK_24 cycles GO is held low before each transaction (at least two 400 kHz periods).
- TIMEOUT_CYCLES, 65535: CLK_24 cycles allowed from GO rise to END; used only with the timeout feature.

Ports:
- CLK_24  in  1  system clock, 24 MHz.
- RESET_N  in  1  asynchronous, active-low reset.
- REQ  in  NREQ  per-requester level request; held until its DONE.
- REQ_OP  in  2*NREQ  operation per requester: 00 write-pointer, 01 read-word, 10 write-word, 11 reserved.
- REQ_PTR  in  8*NREQ  register pointer per requester.
- REQ_WDATA  in  16*NREQ  write data per requester.
- GNT  out  NREQ  one-hot grant, high for the whole transaction.
- DONE  out  NREQ  one-cycle completion pulse to the granted requester.
- ERR  out  1  one-cycle pulse coincident with DONE on a failed transaction.
- RDATA  out  16  read result; valid from the DONE cycle until the next read completes.
- BUSY  out  1  high in every state except IDLE.
- ENG_GO  out  3  level GO to each engine: [0] pointer, [1] read, [2] word.
- ENG_PTR  out  8  pointer to the engines.
- ENG_WDATA  out  16  write data to the word engine.
- ENG_END  in  3  END_OK from each engine; asynchronous to CLK_24.
- ENG_RDATA  in  16  DATA16 from the read engine.

## Operation
States:
- **IDLE**
  - If REQ is zero, stay.
  - Otherwise the picker chooses the first set REQ at or after index (last_grant+1) mod NREQ.
  - Register GNT, OP, ENG_PTR and ENG_WDATA; go to GAP.
- **GAP**
  - ENG_GO=000. Count up to GAP_CYCLES.
  - Leave only when the count is reached and the synchronized END of the selected engine is 0.
  - OP=11: go straight to COMPLETE with ERR.
- **RUN**
  - Drive ENG_GO[OP]=1; the other GO bits stay 0.
  - Wait for the synchronized END[OP]=1, then go to COMPLETE.
- **COMPLETE**
  - For one cycle: DONE[winner]=1; ERR as applicable. Clear GNT and ENG_GO.
  - Read-word with no error: RDATA<=ENG_RDATA.
  - Update last_grant; go to IDLE.

Rules:
- ENG_END[2:0] pass through 2-FF synchronizers. ENG_RDATA is sampled without a synchronizer, because it is stable once END has been high for at least 2 CLK_24 cycles.
- REQ, REQ_OP and REQ_PTR changes are ignored while GNT is high. A withdrawn REQ does not abort the transaction; DONE still pulses.
- The requester drops REQ in the cycle after DONE. A REQ still high when IDLE samples it is a new request.
- last_grant resets to NREQ-1, so requester 0 has first priority after reset.
- Reset, including mid-transaction, asynchronously returns the block to IDLE:
  - GNT, DONE, ERR, BUSY, ENG_GO, ENG_PTR and ENG_WDATA go to 0; RDATA goes to 16'h0000.
  - Dropping GO returns the engines to their idle state.

## Timing
- REQ high at edge N in IDLE gives GNT and BUSY at N+1.
- ENG_GO rises at N+1+GAP_CYCLES at the earliest.
- DONE follows END[OP] rise by 3–4 CLK_24 cycles (2-FF synchronizer plus state register).
- Back-to-back transactions: the next GNT comes at least 2 cycles after DONE (COMPLETE, then IDLE).
- Counters are sized to clog2(param+1) bits and saturate, never wrap.

## Configuration
PMON_ARB_TIMEOUT_EN:
- **Defined:** a RUN-state counter starts at GO rise. When it reaches TIMEOUT_CYCLES with no END, go to COMPLETE with ERR=1 and leave RDATA unchanged. This covers a missing device or a stuck SDA.
- **Undefined:** no counter exists and RUN waits indefinitely. ERR is raised only for OP=11.

## Structure
- Package pmon_arb_pkg holds:
  - op encodings OP_WPTR=2'b00, OP_READ=2'b01, OP_WWORD=2'b10;
  - the state enum {IDLE, GAP, RUN, COMPLETE};
  - engine index constants.
- One sub-module, pmon_rr_picker: combinational round-robin priority selector taking REQ and last_grant, producing a one-hot pick and its index.

## Test plan
- **Single read:** REQ=001, OP=01, PTR=8'h02; END model returns 16'h1F40 → GNT=001 at N+1, ENG_GO=010 after 128 cycles, DONE=001, RDATA=16'h1F40, ERR=0.
- **Contention:** REQ=111 held through three DONEs → grant order 0,1,2; then REQ=101 → next grant is 0.
- **Write-word:** OP=10, PTR=8'h05, WDATA=16'h0A00 → ENG_GO=100, ENG_PTR=8'h05, ENG_WDATA=16'h0A00 stable while GNT is high; RDATA unchanged.
- **Reserved op:** OP=11 → ENG_GO stays 000, DONE and ERR pulse together.
- **Timeout:** with PMON_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=1000, END never rises → ERR+DONE 1000–1001 cycles after GO rise, ENG_GO=000 afterwards.
- **Reset in RUN:** assert RESET_N=0 for one cycle → all outputs 0 immediately; the next request is granted to requester 0.

Source files
------------

// File: rtl/pmon_arb_pkg.sv
// pmon_arb_pkg: op encodings, arbiter states and engine GO decode shared by the PMON I2C arbiter.
package pmon_arb_pkg;

    localparam logic [1:0] OP_WPTR  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WWORD = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    localparam int ENG_PTR_IDX  = 0;
    localparam int ENG_READ_IDX = 1;
    localparam int ENG_WORD_IDX = 2;

    typedef enum logic [1:0] {IDLE, GAP, RUN, COMPLETE} state_t;

    function automatic logic [2:0] op_go(input logic [1:0] op);
        logic [2:0] g;
        g = 3'b000;
        g[ENG_PTR_IDX]  = (op == OP_WPTR);
        g[ENG_READ_IDX] = (op == OP_READ);
        g[ENG_WORD_IDX] = (op == OP_WWORD);
        return g;
    endfunction

endpackage

// File: rtl/pmon_rr_picker.sv
// pmon_rr_picker: combinational round-robin selector, first set REQ at or after last_grant+1.
module pmon_rr_picker #(
    parameter int NREQ = 3,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   idx
);

    logic          found;
    logic [IW-1:0] j;

    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            j = IW'((int'(last_grant) + i) % NREQ);
            if (!found && req[j]) begin
                found   = 1'b1;
                pick[j] = 1'b1;
                idx     = j;
            end
        end
    end

endmodule

// File: rtl/pmon_i2c_arbiter.sv
// pmon_i2c_arbiter: round-robin sharing of the PMON I2C engines with GO/END handshake across clocks.
// Define PMON_ARB_TIMEOUT_EN to abort a RUN that sees no END within TIMEOUT_CYCLES.
module pmon_i2c_arbiter
    import pmon_arb_pkg::*;
#(
    parameter int NREQ           = 3,
    parameter int GAP_CYCLES     = 128,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic               CLK_24,
    input  logic               RESET_N,
    input  logic [NREQ-1:0]    REQ,
    input  logic [2*NREQ-1:0]  REQ_OP,
    input  logic [8*NREQ-1:0]  REQ_PTR,
    input  logic [16*NREQ-1:0] REQ_WDATA,
    output logic [NREQ-1:0]    GNT,
    output logic [NREQ-1:0]    DONE,
    output logic               ERR,
    output logic [15:0]        RDATA,
    output logic               BUSY,
    output logic [2:0]         ENG_GO,
    output logic [7:0]         ENG_PTR,
    output logic [15:0]        ENG_WDATA,
    input  logic [2:0]         ENG_END,
    input  logic [15:0]        ENG_RDATA
);

    localparam int IW = $clog2(NREQ);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    if (NREQ < 2 || NREQ > 8 || GAP_CYCLES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("pmon_i2c_arbiter: parameter out of range");
    end

    state_t          state, state_n;
    logic [NREQ-1:0] pick;
    logic [IW-1:0]   pick_idx, win_idx, last_grant;
    logic [1:0]      op;
    logic [2:0]      go_sel, end_m, end_s;
    logic [GW-1:0]   gap_cnt;
    logic            err_q, err_n, end_hit, gap_done, to_hit;

    pmon_rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
        .req        (REQ),
        .last_grant (last_grant),
        .pick       (pick),
        .idx        (pick_idx)
    );

    assign go_sel   = op_go(op);
    assign end_hit  = |(end_s & go_sel);
    assign gap_done = gap_cnt >= GW'(GAP_CYCLES - 1);
    assign DONE     = (state == COMPLETE) ? GNT : '0;
    assign ERR      = (state == COMPLETE) && err_q;
    assign BUSY     = state != IDLE;

`ifdef PMON_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    assign to_hit = to_cnt >= TW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge CLK_24 or negedge RESET_N) begin
        if (!RESET_N)
            to_cnt <= '0;
        else
            to_cnt <= (state != RUN) ? '0 : (to_cnt == TW'(TIMEOUT_CYCLES)) ? to_cnt : to_cnt + 1'b1;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        err_n   = err_q;
        case (state)
            IDLE: if (|REQ) begin
                state_n = GAP;
                err_n   = 1'b0;
            end
            // A reserved op never touches an engine, so it skips the gap wait.
            GAP: if (op == OP_RSVD) begin
                state_n = COMPLETE;
                err_n   = 1'b1;
            end else if (gap_done && !end_hit) begin
                state_n = RUN;
            end
            RUN: if (end_hit || to_hit) begin
                state_n = COMPLETE;
                err_n   = !end_hit;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK_24 or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= IDLE;
            err_q      <= 1'b0;
            end_m      <= 3'b000;
            end_s      <= 3'b000;
            gap_cnt    <= '0;
            GNT        <= '0;
            win_idx    <= '0;
            last_grant <= IW'(NREQ - 1);
            op         <= OP_WPTR;
            ENG_GO     <= 3'b000;
            ENG_PTR    <= 8'h00;
            ENG_WDATA  <= 16'h0000;
            RDATA      <= 16'h0000;
        end else begin
            state   <= state_n;
            err_q   <= err_n;
            end_m   <= ENG_END;
            end_s   <= end_m;
            gap_cnt <= (state != GAP) ? '0 : (gap_cnt == GW'(GAP_CYCLES)) ? gap_cnt : gap_cnt + 1'b1;
            ENG_GO  <= (state_n == RUN) ? go_sel : 3'b000;
            if (state == IDLE && |REQ) begin
                GNT       <= pick;
                win_idx   <= pick_idx;
                op        <= REQ_OP[{pick_idx, 1'b0} +: 2];
                ENG_PTR   <= REQ_PTR[{pick_idx, 3'b000} +: 8];
                ENG_WDATA <= REQ_WDATA[{pick_idx, 4'b0000} +: 16];
            end
            if (state == COMPLETE) begin
                GNT        <= '0;
                last_grant <= win_idx;
            end
            // END has been high two cycles by now, so read data is settled.
            if (state == RUN && end_hit && op == OP_READ)
                RDATA <= ENG_RDATA;
        end
    end

endmodule

// File: tb/tb_pmon_i2c_arbiter.sv
// tb_pmon_i2c_arbiter: directed checks of grant order, gap/latency timing, ops, reset and optional timeout.
`timescale 1ns/1ps
module tb_pmon_i2c_arbiter;

    logic        CLK_24 = 1'b0;
    logic        RESET_N = 1'b1;
    logic [2:0]  REQ;
    logic [5:0]  REQ_OP;
    logic [23:0] REQ_PTR;
    logic [47:0] REQ_WDATA;
    logic [2:0]  GNT, DONE, ENG_GO, ENG_END;
    logic        ERR, BUSY;
    logic [15:0] RDATA, ENG_WDATA, ENG_RDATA;
    logic [7:0]  ENG_PTR;

    logic        model_en;
    logic [2:0]  g, go_acc;
    int          checks = 0;
    int          errors = 0;
    int          n;

    always #20 CLK_24 = ~CLK_24;

    pmon_i2c_arbiter #(.NREQ(3), .GAP_CYCLES(128), .TIMEOUT_CYCLES(1000)) dut (
        .CLK_24    (CLK_24),
        .RESET_N   (RESET_N),
        .REQ       (REQ),
        .REQ_OP    (REQ_OP),
        .REQ_PTR   (REQ_PTR),
        .REQ_WDATA (REQ_WDATA),
        .GNT       (GNT),
        .DONE      (DONE),
        .ERR       (ERR),
        .RDATA     (RDATA),
        .BUSY      (BUSY),
        .ENG_GO    (ENG_GO),
        .ENG_PTR   (ENG_PTR),
        .ENG_WDATA (ENG_WDATA),
        .ENG_END   (ENG_END),
        .ENG_RDATA (ENG_RDATA)
    );

    // Engine model: END rises 20 cycles (plus 3 ns skew) after GO, falls 3 ns after GO drops.
    initial begin
        ENG_END = 3'b000;
        forever begin
            wait (model_en && ENG_GO != 3'b000);
            g = ENG_GO;
            repeat (20) @(posedge CLK_24);
            #3;
            if (ENG_GO == g) ENG_END = g;
            wait (ENG_GO == 3'b000);
            #3;
            ENG_END = 3'b000;
        end
    end

    task automatic tick();
        @(posedge CLK_24);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_go(input int max, output int cnt);
        cnt = 0;
        while (ENG_GO === 3'b000 && cnt < max) begin
            tick();
            cnt++;
        end
    endtask

    task automatic wait_done(input int max, output int cnt, output logic [2:0] acc);
        cnt = 0;
        acc = 3'b000;
        while (DONE === 3'b000 && cnt < max) begin
            tick();
            cnt++;
            acc |= ENG_GO;
        end
    endtask

    task automatic wait_gnt(input int max, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (GNT === 3'b000 && cnt < max);
    endtask

    initial begin
        REQ = 3'b000;
        REQ_OP = '0;
        REQ_PTR = '0;
        REQ_WDATA = '0;
        ENG_RDATA = 16'h0000;
        model_en = 1'b1;
        #5 RESET_N = 1'b0;
        repeat (3) tick();
        chk("rst_gnt", GNT, 0);
        chk("rst_done", DONE, 0);
        chk("rst_err", ERR, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_go", ENG_GO, 0);
        chk("rst_ptr", ENG_PTR, 0);
        chk("rst_wdata", ENG_WDATA, 0);
        chk("rst_rdata", RDATA, 0);
        RESET_N = 1'b1;
        tick();

        REQ_OP[1:0] = 2'b01;
        REQ_PTR[7:0] = 8'h02;
        ENG_RDATA = 16'h1F40;
        REQ = 3'b001;
        tick();
        chk("read_gnt", GNT, 3'b001);
        chk("read_busy", BUSY, 1);
        wait_go(300, n);
        chk("read_gap_len", n, 128);
        chk("read_go", ENG_GO, 3'b010);
        chk("read_ptr", ENG_PTR, 8'h02);
        wait_done(100, n, go_acc);
        chk("read_latency", n, 23);
        chk("read_done", DONE, 3'b001);
        chk("read_err", ERR, 0);
        chk("read_rdata", RDATA, 16'h1F40);
        REQ = 3'b000;
        tick();
        chk("read_done_pulse", DONE, 0);
        chk("read_gnt_clear", GNT, 0);
        chk("read_idle", BUSY, 0);

        REQ_OP[3:2] = 2'b11;
        REQ = 3'b010;
        tick();
        chk("rsvd_gnt", GNT, 3'b010);
        wait_done(10, n, go_acc);
        chk("rsvd_latency", n, 1);
        chk("rsvd_done", DONE, 3'b010);
        chk("rsvd_err", ERR, 1);
        chk("rsvd_no_go", go_acc, 0);
        chk("rsvd_rdata", RDATA, 16'h1F40);
        REQ = 3'b000;
        tick();
        chk("rsvd_err_pulse", ERR, 0);

        REQ_OP[5:4] = 2'b10;
        REQ_PTR[23:16] = 8'h05;
        REQ_WDATA[47:32] = 16'h0A00;
        ENG_RDATA = 16'hDEAD;
        REQ = 3'b100;
        tick();
        chk("ww_gnt", GNT, 3'b100);
        REQ_PTR[23:16] = 8'hFF;
        REQ_WDATA[47:32] = 16'hFFFF;
        REQ_OP[5:4] = 2'b01;
        wait_go(300, n);
        chk("ww_go", ENG_GO, 3'b100);
        chk("ww_ptr", ENG_PTR, 8'h05);
        chk("ww_wdata", ENG_WDATA, 16'h0A00);
        wait_done(100, n, go_acc);
        chk("ww_done", DONE, 3'b100);
        chk("ww_err", ERR, 0);
        chk("ww_ptr_hold", ENG_PTR, 8'h05);
        chk("ww_wdata_hold", ENG_WDATA, 16'h0A00);
        chk("ww_rdata", RDATA, 16'h1F40);

        REQ_OP = '0;
        REQ = 3'b111;
        for (int k = 0; k < 3; k++) begin
            wait_gnt(5, n);
            chk("cont_gnt", GNT, 3'b001 << k);
            chk("cont_spacing", n, 2);
            wait_go(300, n);
            wait_done(100, n, go_acc);
            chk("cont_done", DONE, 3'b001 << k);
        end
        REQ = 3'b101;
        wait_gnt(5, n);
        chk("cont_wrap_gnt", GNT, 3'b001);
        REQ = 3'b000;
        wait_go(300, n);
        wait_done(100, n, go_acc);
        chk("cont_wrap_done", DONE, 3'b001);

        model_en = 1'b0;
        REQ_OP[1:0] = 2'b01;
        REQ_PTR[7:0] = 8'h02;
        REQ = 3'b001;
        wait_gnt(5, n);
        chk("rr_gnt", GNT, 3'b001);
        wait_go(300, n);
        chk("rr_go", ENG_GO, 3'b010);
        repeat (5) tick();
        #5 RESET_N = 1'b0;
        #1;
        chk("rr_gnt_clr", GNT, 0);
        chk("rr_busy_clr", BUSY, 0);
        chk("rr_go_clr", ENG_GO, 0);
        chk("rr_ptr_clr", ENG_PTR, 0);
        chk("rr_wdata_clr", ENG_WDATA, 0);
        chk("rr_rdata_clr", RDATA, 0);
        chk("rr_done_clr", DONE, 0);
        REQ = 3'b111;
        @(posedge CLK_24);
        #5 RESET_N = 1'b1;
        model_en = 1'b1;
        ENG_RDATA = 16'h5A5A;
        tick();
        chk("rr_first_gnt", GNT, 3'b001);
        REQ = 3'b000;
        wait_go(300, n);
        wait_done(100, n, go_acc);
        chk("rr_withdrawn_done", DONE, 3'b001);
        chk("rr_rdata", RDATA, 16'h5A5A);
        chk("rr_err", ERR, 0);

`ifdef PMON_ARB_TIMEOUT_EN
        model_en = 1'b0;
        REQ = 3'b001;
        wait_gnt(5, n);
        wait_go(300, n);
        chk("to_go", ENG_GO, 3'b010);
        wait_done(1100, n, go_acc);
        chk("to_latency", n, 1000);
        chk("to_done", DONE, 3'b001);
        chk("to_err", ERR, 1);
        chk("to_rdata", RDATA, 16'h5A5A);
        REQ = 3'b000;
        tick();
        chk("to_go_clr", ENG_GO, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
